// File: rtl/led_conf_pkg.sv
// Shared constants for the LED timing configuration block: register map and commit FSM states.
package led_conf_pkg;

  localparam logic [1:0] REG_T0H = 2'd0;
  localparam logic [1:0] REG_T0L = 2'd1;
  localparam logic [1:0] REG_T1H = 2'd2;
  localparam logic [1:0] REG_T1L = 2'd3;
  localparam int         NUM_REGS = 4;

  localparam logic [5:0] ADDR_COMMIT = 6'h3C;
  localparam logic [5:0] ADDR_MODE   = 6'h3D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    APPLY = 2'd2
  } conf_state_t;

  function automatic logic is_commit(input logic wr_en, input logic [5:0] addr,
                                     input logic [7:0] data);
    return wr_en && (addr == ADDR_COMMIT) && data[0];
  endfunction

endpackage

// File: rtl/led_timing_conf_if.sv
// Host-side register bus of the LED timing block: write port, readback address and frame strobe.
interface led_timing_conf_if;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] rd_addr;
  logic       frame_done;

  modport master (output wr_en, wr_addr, wr_data, rd_addr, frame_done);
  modport slave  (input  wr_en, wr_addr, wr_data, rd_addr, frame_done);
endinterface

// File: rtl/led_timing_chan.sv
// One LED channel: shadow and active copies of the four bit-timing counts, zero writes clamp to 1.
module led_timing_chan
  import led_conf_pkg::*;
#(
  parameter int                   CNT_WIDTH = 8,
  parameter logic [3:0]           CH_IDX    = 4'd0,
  parameter logic [CNT_WIDTH-1:0] T0H_DEF   = 8'h01,
  parameter logic [CNT_WIDTH-1:0] T0L_DEF   = 8'h12,
  parameter logic [CNT_WIDTH-1:0] T1H_DEF   = 8'h23,
  parameter logic [CNT_WIDTH-1:0] T1L_DEF   = 8'h34
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  led_timing_conf_if.slave                      bus,
  input  logic                                  apply_in,
  output logic [NUM_REGS-1:0][CNT_WIDTH-1:0]    shadow_out,
  output logic [NUM_REGS-1:0][CNT_WIDTH-1:0]    active_out
);

  localparam logic [NUM_REGS-1:0][CNT_WIDTH-1:0] DEF_VEC = {T1L_DEF, T1H_DEF, T0L_DEF, T0H_DEF};

  logic [NUM_REGS-1:0][CNT_WIDTH-1:0] r_shadow;
  logic [NUM_REGS-1:0][CNT_WIDTH-1:0] r_active;
  logic [CNT_WIDTH-1:0]               w_wr_val;
  logic                               w_hit;

  // Channel 15 aliases the control addresses; CH_IDX never reaches it.
  assign w_hit    = bus.wr_en && (bus.wr_addr[5:2] == CH_IDX);
  assign w_wr_val = (bus.wr_data[CNT_WIDTH-1:0] == '0) ? CNT_WIDTH'(1)
                                                        : bus.wr_data[CNT_WIDTH-1:0];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_shadow <= DEF_VEC;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_hit && (bus.wr_addr[1:0] == 2'(i)))
          r_shadow[i] <= w_wr_val;
      end
    end
  end

  // Active takes the pre-edge shadow, so a write in the apply cycle stays in shadow only.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      r_active <= DEF_VEC;
    else if (apply_in)
      r_active <= r_shadow;
  end

  assign shadow_out = r_shadow;
  assign active_out = r_active;

endmodule

// File: rtl/led_timing_conf.sv
// LED timing configuration: per-channel shadow/active counts with a frame-synchronised commit FSM.
module led_timing_conf
  import led_conf_pkg::*;
#(
  parameter int                   CH_NUM    = 4,
  parameter int                   CNT_WIDTH = 8,
  parameter logic [CNT_WIDTH-1:0] T0H_DEF   = 8'h01,
  parameter logic [CNT_WIDTH-1:0] T0L_DEF   = 8'h12,
  parameter logic [CNT_WIDTH-1:0] T1H_DEF   = 8'h23,
  parameter logic [CNT_WIDTH-1:0] T1L_DEF   = 8'h34
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          wr_en_in,
  input  logic [5:0]                    wr_addr_in,
  input  logic [7:0]                    wr_data_in,
  input  logic [5:0]                    rd_addr_in,
  output logic [7:0]                    rd_data_out,
  input  logic                          frame_done_in,
  output logic [CH_NUM*CNT_WIDTH-1:0]   t0h_cnt_out,
  output logic [CH_NUM*CNT_WIDTH-1:0]   t0l_cnt_out,
  output logic [CH_NUM*CNT_WIDTH-1:0]   t1h_cnt_out,
  output logic [CH_NUM*CNT_WIDTH-1:0]   t1l_cnt_out,
  output logic                          pending_out,
  output logic                          update_done_out
);

  led_timing_conf_if u_bus ();

  assign u_bus.wr_en      = wr_en_in;
  assign u_bus.wr_addr    = wr_addr_in;
  assign u_bus.wr_data    = wr_data_in;
  assign u_bus.rd_addr    = rd_addr_in;
  assign u_bus.frame_done = frame_done_in;

  conf_state_t r_state;
  conf_state_t w_state_next;
  logic        r_mode;
  logic [7:0]  r_rd_data;
  logic [7:0]  w_rd_next;
  logic        w_commit;
  logic        w_apply;

  logic [NUM_REGS-1:0][CNT_WIDTH-1:0] w_shadow [CH_NUM];
  logic [NUM_REGS-1:0][CNT_WIDTH-1:0] w_active [CH_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_chan
      led_timing_chan #(
        .CNT_WIDTH (CNT_WIDTH),
        .CH_IDX    (4'(gi)),
        .T0H_DEF   (T0H_DEF),
        .T0L_DEF   (T0L_DEF),
        .T1H_DEF   (T1H_DEF),
        .T1L_DEF   (T1L_DEF)
      ) u_chan (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .bus        (u_bus),
        .apply_in   (w_apply),
        .shadow_out (w_shadow[gi]),
        .active_out (w_active[gi])
      );

      assign t0h_cnt_out[gi*CNT_WIDTH +: CNT_WIDTH] = w_active[gi][REG_T0H];
      assign t0l_cnt_out[gi*CNT_WIDTH +: CNT_WIDTH] = w_active[gi][REG_T0L];
      assign t1h_cnt_out[gi*CNT_WIDTH +: CNT_WIDTH] = w_active[gi][REG_T1H];
      assign t1l_cnt_out[gi*CNT_WIDTH +: CNT_WIDTH] = w_active[gi][REG_T1L];
    end
  endgenerate

  assign w_commit = is_commit(u_bus.wr_en, u_bus.wr_addr, u_bus.wr_data);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  // A frame pulse coinciding with the commit only arms; the next frame pulse applies.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_commit) w_state_next = r_mode ? APPLY : ARMED;
      ARMED:   if (u_bus.frame_done) w_state_next = APPLY;
      APPLY:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_apply         = (r_state == APPLY);
  assign update_done_out = w_apply;
  assign pending_out     = (r_state == ARMED);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      r_mode <= 1'b0;
    else if (u_bus.wr_en && (u_bus.wr_addr == ADDR_MODE))
      r_mode <= u_bus.wr_data[0];
  end

  // Control addresses decode as channel 15, which is never populated.
  always_comb begin
    w_rd_next = '0;
    if (u_bus.rd_addr == ADDR_COMMIT) begin
      w_rd_next = {6'b0, pending_out, r_mode};
    end else if (u_bus.rd_addr == ADDR_MODE) begin
      w_rd_next = {7'b0, r_mode};
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (u_bus.rd_addr[5:2] == 4'(c))
          w_rd_next = 8'(w_shadow[c][u_bus.rd_addr[1:0]]);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      r_rd_data <= '0;
    else
      r_rd_data <= w_rd_next;
  end

  assign rd_data_out = r_rd_data;

endmodule
